// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between aes_round_ctrl and its environment.
// Carries the decrypt request when AES_ROUND_CTRL_DECRYPT_EN is defined.
interface aes_round_ctrl_if;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] key_len;
   logic       dp_en;
   logic       dp_valid;
   logic       dp_load;
   logic       dp_final;
   logic [3:0] rk_idx;
   logic       dp_valid_ret;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       err;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   logic       decrypt;

   modport master (
      input  in_valid, key_len, dp_valid_ret, out_ready, decrypt,
      output in_ready, dp_en, dp_valid, dp_load, dp_final, rk_idx, out_valid, busy, err
   );
   modport slave (
      output in_valid, key_len, dp_valid_ret, out_ready, decrypt,
      input  in_ready, dp_en, dp_valid, dp_load, dp_final, rk_idx, out_valid, busy, err
   );
`else
   modport master (
      input  in_valid, key_len, dp_valid_ret, out_ready,
      output in_ready, dp_en, dp_valid, dp_load, dp_final, rk_idx, out_valid, busy, err
   );
   modport slave (
      output in_valid, key_len, dp_valid_ret, out_ready,
      input  in_ready, dp_en, dp_valid, dp_load, dp_final, rk_idx, out_valid, busy, err
   );
`endif
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath (sub_bytes, shift_rows, mix_columns, add_round_key).
// Defining AES_ROUND_CTRL_DECRYPT_EN adds a decrypt request that runs the round keys in reverse.
module aes_round_ctrl #(
   parameter int STAGE_LAT = 4
) (
   input logic          clk,
   input logic          rst,
   aes_round_ctrl_if.master ctl
);
   localparam logic [3:0] LAT = 4'(STAGE_LAT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] nr_q, nr_d;
   logic [3:0] round_q, round_d;
   logic [3:0] lat_q, lat_d;
   logic [3:0] rk_idx_q, rk_idx_d;
   logic       out_valid_q, out_valid_d;
   logic       err_q, err_d;
   logic       dec_q, dec_d;

   logic       new_dec;
   logic [3:0] issue_rk;
   logic       dp_en, dp_valid, dp_load, dp_final;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
   assign new_dec = ctl.decrypt;
`else
   assign new_dec = 1'b0;
`endif

   function automatic logic [3:0] rounds_for(input logic [1:0] kl);
      case (kl)
         2'b01:   return 4'd12;
         2'b10:   return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   // Decryption walks the schedule backwards: round r uses key Nr-r.
   function automatic logic [3:0] rk_for(input logic [3:0] rnd, input logic [3:0] nr,
                                         input logic dec);
      return dec ? (nr - rnd) : rnd;
   endfunction

   always_comb begin
      state_d     = state_q;
      nr_d        = nr_q;
      round_d     = round_q;
      lat_d       = lat_q;
      rk_idx_d    = rk_idx_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      dec_d       = dec_q;
      issue_rk    = rk_idx_q;
      dp_en       = 1'b1;
      dp_valid    = 1'b0;
      dp_load     = 1'b0;
      dp_final    = 1'b0;

      case (state_q)
         IDLE: begin
            if (ctl.in_valid) begin
               nr_d     = rounds_for(ctl.key_len);
               dec_d    = new_dec;
               round_d  = 4'd1;
               lat_d    = 4'd1;
               issue_rk = rk_for(4'd1, nr_d, new_dec);
               rk_idx_d = issue_rk;
               dp_valid = 1'b1;
               dp_load  = 1'b1;
               state_d  = WAIT;
            end
         end

         WAIT: begin
            if (ctl.dp_valid_ret && lat_q == LAT) begin
               if (round_q < nr_q) begin
                  round_d  = round_q + 4'd1;
                  lat_d    = 4'd1;
                  issue_rk = rk_for(round_d, nr_q, dec_q);
                  rk_idx_d = issue_rk;
                  dp_valid = 1'b1;
                  dp_final = (round_d == nr_q);
               end else begin
                  // Last result is sitting in the final stage: freeze it there.
                  dp_en       = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end else if (ctl.dp_valid_ret || lat_q == LAT) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               lat_d = lat_q + 4'd1;
            end
         end

         DONE: begin
            dp_en = 1'b0;
            if (ctl.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         nr_q        <= 4'd0;
         round_q     <= 4'd0;
         lat_q       <= 4'd0;
         rk_idx_q    <= 4'd0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         dec_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         nr_q        <= nr_d;
         round_q     <= round_d;
         lat_q       <= lat_d;
         rk_idx_q    <= rk_idx_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         dec_q       <= dec_d;
      end
   end

   // The issued index is visible in its issue cycle; otherwise the last one is held.
   assign ctl.rk_idx    = dp_valid ? issue_rk : rk_idx_q;
   assign ctl.dp_en     = dp_en;
   assign ctl.dp_valid  = dp_valid;
   assign ctl.dp_load   = dp_load;
   assign ctl.dp_final  = dp_final;
   assign ctl.in_ready  = (state_q == IDLE);
   assign ctl.busy      = (state_q != IDLE);
   assign ctl.out_valid = out_valid_q;
   assign ctl.err       = err_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a 4-stage AES round datapath closes the loop, and a schedule
// model (Nr from key_len, issue every LAT cycles) predicts every controller output.
module tb_aes_round_ctrl;
   localparam int LAT = 4;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_round_ctrl_if bus ();
   aes_round_ctrl #(.STAGE_LAT(LAT)) dut (.clk(clk), .rst(rst), .ctl(bus));

   int n_chk = 0;
   int n_pass = 0;
   int fault_mode = 0;
   logic [127:0] pt;
   logic [7:0]   sbox_t [256];
   logic [127:0] rk [15];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] byte_of(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_t[s[8*i +: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = byte_of(s, r + 4*((c + r) % 4));
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = byte_of(s, 4*c);
         a1 = byte_of(s, 4*c+1);
         a2 = byte_of(s, 4*c+2);
         a3 = byte_of(s, 4*c+3);
         o[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                              a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
      end
      return o;
   endfunction

   task automatic init_tables(input logic [127:0] key);
      logic [7:0]  inv, rc;
      logic [31:0] w [60];
      logic [31:0] t;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         repeat (254) inv = gmul(inv, 8'(x));
         sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 60; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Datapath: sub_bytes | shift_rows | mix_columns (bypassed on final) | add_round_key
   logic [127:0] st1, st2, st3, st4;
   logic         v1, v2, v3, v4, f1, f2, ret;
   logic [3:0]   k1, k2, k3;

   always @(posedge clk or posedge rst) begin
      if (rst) {v1, v2, v3, v4} <= 4'b0000;
      else if (bus.dp_en) {v1, v2, v3, v4} <= {bus.dp_valid, v1, v2, v3};
   end

   always @(posedge clk) begin
      if (bus.dp_en) begin
         if (bus.dp_valid) begin
            st1 <= sub_bytes(bus.dp_load ? (pt ^ rk[0]) : st4);
            f1  <= bus.dp_final;
            k1  <= bus.rk_idx;
         end
         st2 <= shift_rows(st1);
         f2  <= f1;
         k2  <= k1;
         st3 <= f2 ? st2 : mix_columns(st2);
         k3  <= k2;
         st4 <= st3 ^ rk[k3];
      end
   end

   always_comb begin
      ret = v4;
      case (fault_mode)
         1: ret = v3;
         2: ret = 1'b0;
         3: ret = 1'b1;
         default: ret = v4;
      endcase
   end
   assign bus.dp_valid_ret = ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk128(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic int model_nr(input logic [1:0] kl);
      return (kl == 2'b01) ? 12 : (kl == 2'b10) ? 14 : 10;
   endfunction

   // Entered and left just after a falling edge with the controller idle.
   task automatic run_block(input logic [1:0] kl, input logic dec, input logic [127:0] p,
                            input int hold, input logic chk_ct, input logic [127:0] ct);
      int nr, k, n_iss, ready_hi, bad;
      int iss_off [16];
      int iss_rk [16];
      logic iss_fin [16];
      logic [127:0] held;
      nr = model_nr(kl);
      pt = p;
      bus.key_len  = kl;
      bus.in_valid = 1'b1;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      bus.decrypt = dec;
`endif
      #1;
      chk("accept_ready", 32'(bus.in_ready), 32'd1);
      chk("accept_load", 32'(bus.dp_valid & bus.dp_load), 32'd1);
      iss_off[0] = 0;
      iss_rk[0]  = int'(bus.rk_idx);
      iss_fin[0] = bus.dp_final;
      n_iss = 1;
      ready_hi = 0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         bus.in_valid = 1'b0;
         bus.key_len  = 2'($urandom);
         #1;
         if (bus.in_ready) ready_hi++;
         if (bus.dp_valid && n_iss < 16) begin
            iss_off[n_iss] = k;
            iss_rk[n_iss]  = int'(bus.rk_idx);
            iss_fin[n_iss] = bus.dp_final;
            n_iss++;
         end
      end while (!bus.out_valid && k < nr*LAT + 20);
      chk("busy_not_ready", ready_hi, 0);
      chk("out_valid_time", k, nr*LAT + 1);
      chk("issue_count", n_iss, nr);
      for (int j = 0; j < n_iss; j++) begin
         chk("issue_time", iss_off[j], j*LAT);
         chk("issue_rk", iss_rk[j], dec ? (nr - 1 - j) : (j + 1));
         chk("issue_final", 32'(iss_fin[j]), 32'(j == nr - 1));
      end
      chk("done_dp_en", 32'(bus.dp_en), 32'd0);
      if (chk_ct) chk128("ciphertext", st4, ct);
      held = st4;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         #1;
         if (!bus.out_valid || bus.dp_en || bus.in_ready || st4 !== held) bad++;
      end
      chk("hold_stable", bad, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_dp_en", 32'(bus.dp_en), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, bad;
      init_tables(C1_KEY);
      bus.in_valid  = 1'b0;
      bus.key_len   = 2'b00;
      bus.out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      bus.decrypt = 1'b0;
`endif
      pt = '0;
      idle(3);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_dp_en", 32'(bus.dp_en), 32'd1);
      chk("rst_dp_valid", 32'(bus.dp_valid), 32'd0);
      chk("rst_rk_idx", 32'(bus.rk_idx), 32'd0);
      rst = 1'b0;
      idle(1);

      // FIPS-197 C.1 with long backpressure, then back-to-back AES-256
      run_block(2'b00, 1'b0, C1_PT, 20, 1'b1, C1_CT);
      run_block(2'b10, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, '0);
      idle(2);
      run_block(2'b11, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         idle($urandom_range(0, 3));
         run_block(2'($urandom), 1'b0, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 4), 1'b0, '0);
      end

      // Asynchronous reset in round 5
      pt = {$urandom, $urandom, $urandom, $urandom};
      bus.key_len  = 2'b00;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      k = 0;
      while (!(bus.dp_valid && bus.rk_idx == 4'd5) && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("reach_round5", 32'(bus.rk_idx), 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("async_in_ready", 32'(bus.in_ready), 32'd1);
      chk("async_busy", 32'(bus.busy), 32'd0);
      chk("async_rk_idx", 32'(bus.rk_idx), 32'd0);
      chk("async_dp_valid", 32'(bus.dp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      run_block(2'b00, 1'b0, C1_PT, 1, 1'b1, C1_CT);

`ifdef AES_ROUND_CTRL_DECRYPT_EN
      run_block(2'b00, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, '0);
      run_block(2'b01, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, '0);
      bus.decrypt = 1'b0;
`endif

      // Return pulses while idle are ignored
      fault_mode = 3;
      idle(3);
      chk("idle_ret_err", 32'(bus.err), 32'd0);
      chk("idle_ret_busy", 32'(bus.busy), 32'd0);
      fault_mode = 0;
      idle(2);

      // Early return at lat=3
      fault_mode = 1;
      bus.key_len  = 2'b00;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      idle(2);
      chk("early_err_pending", 32'(bus.err), 32'd0);
      idle(1);
      chk("early_err", 32'(bus.err), 32'd1);
      chk("early_in_ready", 32'(bus.in_ready), 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         idle(1);
         if (bus.out_valid) bad++;
      end
      chk("early_no_out", bad, 0);
      fault_mode = 0;
      rst = 1'b1;
      #1;
      chk("err_cleared", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Withheld return
      fault_mode = 2;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      idle(3);
      chk("late_err_pending", 32'(bus.err), 32'd0);
      chk("late_busy", 32'(bus.busy), 32'd1);
      idle(1);
      chk("late_err", 32'(bus.err), 32'd1);
      chk("late_in_ready", 32'(bus.in_ready), 32'd1);
      chk("late_out_valid", 32'(bus.out_valid), 32'd0);
      fault_mode = 0;
      idle(3);
      chk("err_sticky", 32'(bus.err), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("err_reset", 32'(bus.err), 32'd0);
      run_block(2'($urandom), 1'b0, {$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, '0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
